// File: rtl/i2s_transmitter.sv
// I2S transmitter: one-entry sample buffer feeding a free-running 64-BCLK frame.
// Left/right slots alternate; each 24-bit sample follows its lrclk edge by one BCLK, MSB first.
module i2s_transmitter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
);

  localparam int unsigned SAMPLE_W  = 24;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned BIT_W     = 6;
  localparam int unsigned SLOT_W    = 5;
  localparam int unsigned LOAD_SLOT = 1;
  localparam int unsigned LAST_SLOT = 24;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [BIT_W-1:0]    b_q, b_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] buf_q, buf_d;
  logic                full_q, full_d;
  logic                in_ready_q, in_ready_d;

  logic                wrap;
  logic                fall;
  logic                load;
  logic                handshake;
  logic [SLOT_W-1:0]   slot;

  // Bit-clock divider and frame position.
  always_comb begin
    wrap   = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = wrap ? '0 : div_q + DIV_W'(1);
    bclk_d = wrap ? ~bclk_q : bclk_q;
    fall   = wrap & bclk_q;
    b_d    = fall ? b_q + BIT_W'(1) : b_q;
    slot   = b_d[SLOT_W-1:0];
  end

  // Serializer: everything here moves only on BCLK falling events.
  always_comb begin
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    if (fall) begin
      lrclk_d = b_d[BIT_W-1];
      if (slot == SLOT_W'(LOAD_SLOT)) begin
        load = 1'b1;
        if (full_q) begin
          sdata_d = buf_q[SAMPLE_W-1];
          shift_d = {buf_q[SAMPLE_W-2:0], 1'b0};
        end else begin
          sdata_d    = 1'b0;
          shift_d    = '0;
          underrun_d = 1'b1;
        end
      end else if ((slot > SLOT_W'(LOAD_SLOT)) && (slot <= SLOT_W'(LAST_SLOT))) begin
        sdata_d = shift_q[SAMPLE_W-1];
        shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  // Holding buffer; a load that finds it empty may coincide with a refill.
  always_comb begin
    handshake  = in_valid & in_ready_q;
    full_d     = full_q;
    buf_d      = buf_q;
    if (load) begin
      full_d = 1'b0;
    end
    if (handshake) begin
      full_d = 1'b1;
      buf_d  = in_data;
    end
    in_ready_d = ~full_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      b_q        <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      shift_q    <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      b_q        <= b_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at CLK_DIV=2: frames are captured at bclk rises
// and compared against hand-built 64-bit frame images.
module tb_i2s_transmitter;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned RISE_SPAN = 63 * 2 * CLK_DIV;
  localparam int          GUARD     = 400;

  logic        clk      = 1'b0;
  logic        resetn   = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data  = 24'h0;
  logic        in_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  i2s_transmitter #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          rise_cnt = 0;
  int          cyc_cnt  = 0;
  int          t0       = 0;
  int          t63      = 0;
  int          fr_und   = 0;
  int          fr_hs    = 0;
  logic        prev_bclk  = 1'b0;
  logic        pending_hs = 1'b0;
  logic [63:0] cap_d  = 64'h0;
  logic [63:0] cap_lr = 64'h0;
  logic [23:0] feed[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_bclk"},     64'(bclk),     64'h0);
    chk({tag, "_lrclk"},    64'(lrclk),    64'h0);
    chk({tag, "_sdata"},    64'(sdata),    64'h0);
    chk({tag, "_underrun"}, 64'(underrun), 64'h0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'h0);
  endtask

  // Present the head of the feed queue; a handshake lands on the coming posedge.
  task automatic feed_drive();
    in_valid   = (feed.size() != 0);
    in_data    = in_valid ? feed[0] : 24'h0;
    pending_hs = in_valid && in_ready;
    if (pending_hs) fr_hs++;
  endtask

  task automatic cyc();
    int b;
    @(negedge clk);
    cyc_cnt++;
    if (pending_hs) void'(feed.pop_front());
    if (underrun) fr_und++;
    if (bclk && !prev_bclk) begin
      b = rise_cnt % 64;
      cap_d[63-b]  = sdata;
      cap_lr[63-b] = lrclk;
      if (b == 0)  t0  = cyc_cnt;
      if (b == 63) t63 = cyc_cnt;
      rise_cnt++;
    end
    prev_bclk = bclk;
    feed_drive();
  endtask

  task automatic release_reset();
    resetn    = 1'b1;
    rise_cnt  = 0;
    prev_bclk = 1'b0;
    fr_und    = 0;
    fr_hs     = 0;
  endtask

  task automatic run_frame(input string tag, input logic [23:0] l, input logic [23:0] r,
                           input int und, input int hs);
    int target;
    int guard;
    target = (rise_cnt / 64 + 1) * 64;
    guard  = 0;
    while (rise_cnt < target && guard < GUARD) begin
      cyc();
      guard++;
    end
    chk({tag, "_done"},  64'(rise_cnt >= target), 64'h1);
    chk({tag, "_data"},  cap_d,  {1'b0, l, 7'b0, 1'b0, r, 7'b0});
    chk({tag, "_lrclk"}, cap_lr, {32'h0, 32'hFFFF_FFFF});
    chk({tag, "_und"},   64'(fr_und), 64'(und));
    chk({tag, "_hs"},    64'(fr_hs),  64'(hs));
    chk({tag, "_span"},  64'(t63 - t0), 64'(RISE_SPAN));
    fr_und = 0;
    fr_hs  = 0;
  endtask

  initial begin
    int base;
    int guard;
    logic und_seen;

    resetn = 1'b0;
    repeat (5) @(negedge clk);
    chk_quiet("reset");

    // Stream L/R with underrun-free start.
    feed.push_back(24'hABCDEF);
    feed.push_back(24'h123456);
    feed_drive();
    release_reset();
    cyc();
    chk("rel_in_ready", 64'(in_ready), 64'h1);
    chk("rel_bclk_lo",  64'(bclk),     64'h0);
    cyc();
    chk("rel_bclk_hi",  64'(bclk),     64'h1);
    run_frame("stream", 24'hABCDEF, 24'h123456, 0, 2);

    // Starved for three frames.
    run_frame("under0", 24'h0, 24'h0, 2, 0);
    run_frame("under1", 24'h0, 24'h0, 2, 0);
    run_frame("under2", 24'h0, 24'h0, 2, 0);

    feed.push_back(24'h800000);
    feed.push_back(24'h7FFFFF);
    feed_drive();
    run_frame("extreme", 24'h800000, 24'h7FFFFF, 0, 2);

    // in_valid held high with a counter: buffer refills right after each load.
    for (int i = 0; i < 10; i++) feed.push_back(24'h40C000 + 24'(i));
    feed_drive();
    run_frame("bp0", 24'h40C000, 24'h40C001, 0, 3);
    chk("bp0_in_ready", 64'(in_ready), 64'h0);
    run_frame("bp1", 24'h40C002, 24'h40C003, 0, 2);
    chk("bp1_in_ready", 64'(in_ready), 64'h0);
    run_frame("bp2", 24'h40C004, 24'h40C005, 0, 2);
    chk("bp2_in_ready", 64'(in_ready), 64'h0);

    // Run into left s=10 of the next frame (0x40C006 bit 14 = 1), then reset.
    base  = rise_cnt;
    guard = 0;
    while (rise_cnt < base + 11 && guard < GUARD) begin
      cyc();
      guard++;
    end
    chk("mid_reach", 64'(rise_cnt), 64'(base + 11));
    chk("mid_s10_bit", 64'(sdata), 64'h1);
    resetn     = 1'b0;
    feed.delete();
    pending_hs = 1'b0;
    in_valid   = 1'b0;
    in_data    = 24'h0;
    #1;
    chk_quiet("midrst_async");
    und_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      und_seen = und_seen | underrun;
    end
    chk("midrst_underrun", 64'(und_seen), 64'h0);

    feed.push_back(24'h5A5A5A);
    feed.push_back(24'h0F0F0F);
    feed_drive();
    release_reset();
    run_frame("after_rst", 24'h5A5A5A, 24'h0F0F0F, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
